// File: rtl/flash_copy_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// flash_copy_ctrl_pkg
// Shared definitions for the flash copy controller and its watchdog.
//   state_e              controller states, walked once per copy job
//   CMD_READ_DATA_BYTES  opcode the SPI flash reader issues for sequential reads
//   WD_W                 width of the watchdog counter and its TIMEOUT value
//   isGuardedState()     states in which the controller waits on a handshake
//                        and must therefore be protected by the watchdog
// ---------------------------------------------------------------------------
package flash_copy_ctrl_pkg;

    localparam logic [7:0] CMD_READ_DATA_BYTES = 8'h03;

    localparam int WD_W = 24;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        WAIT_RDY,
        CMD,
        WAIT_DATA,
        WRITE,
        NEXT,
        TERM,
        FIN
    } state_e;

    // Only the states that wait on the reader or the memory port can stall
    // forever, so only these run the watchdog.
    function automatic logic isGuardedState(input state_e s);
        return (s == WAIT_RDY) || (s == WAIT_DATA) || (s == WRITE);
    endfunction

endpackage

// File: rtl/flash_copy_ctrl_watchdog.sv
// ---------------------------------------------------------------------------
// flash_copy_ctrl_watchdog
// Counts cycles spent in a single controller state and flags when the count
// reaches TIMEOUT.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clear_i    restart counting from zero (the controller changed state)
//   enable_i   count this cycle (controller sits in a guarded state)
//   expired_o  this is the TIMEOUT-th cycle in the current guarded state
// ---------------------------------------------------------------------------
module flash_copy_ctrl_watchdog
    import flash_copy_ctrl_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT = 24'd2000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;
    logic            atLimit;

    // The count holds the number of cycles already spent in the state, so
    // the TIMEOUT-th cycle is the one where it equals TIMEOUT-1.  The expired
    // flag deliberately ignores clear_i: clear_i is derived from the
    // controller's next state, which in turn depends on expired_o.
    always_comb begin
        atLimit   = (count_q == (TIMEOUT - 1'b1));
        expired_o = enable_i && atLimit;
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !atLimit) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flash_copy_ctrl.sv
// ---------------------------------------------------------------------------
// flash_copy_ctrl
// Job sequencer that copies len bytes from SPI flash (through the byte
// reader) into a byte-wide memory write port.  The controller owns the
// reader's reset and pulses it before every job except the first one after
// a system reset, so the reader re-arms after each terminate.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, src_addr, dst_addr, len job request and its parameters
//   busy, done, error             job status (error is sticky until next start)
//   fl_rst_n, fl_addr, fl_rd,
//   fl_terminate                  controls towards the flash reader
//   fl_dout, fl_data_ready,
//   fl_busy                       status and data from the flash reader
//   mem_addr, mem_wdata, mem_we   memory write request (held until mem_ack)
//   mem_ack                       memory write accepted
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module flash_copy_ctrl
    import flash_copy_ctrl_pkg::*;
#(
    parameter int              DST_AW  = 16,
    parameter int              LEN_W   = 16,
    parameter logic [WD_W-1:0] TIMEOUT = 24'd2000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [23:0]       src_addr,
    input  logic [DST_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              fl_rst_n,
    output logic [23:0]       fl_addr,
    output logic              fl_rd,
    output logic              fl_terminate,
    input  logic [7:0]        fl_dout,
    input  logic              fl_data_ready,
    input  logic              fl_busy,
    output logic [DST_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic              used_q, used_d;
    logic [23:0]       srcAddr_q, srcAddr_d;
    logic [DST_AW-1:0] curDst_q, curDst_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              firstWait_q, firstWait_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              flRstN_q, flRstN_d;
    logic [23:0]       flAddr_q, flAddr_d;
    logic              flRd_q, flRd_d;
    logic              flTerm_q, flTerm_d;
    logic [DST_AW-1:0] memAddr_q, memAddr_d;
    logic [7:0]        memWdata_q, memWdata_d;
    logic              memWe_q, memWe_d;

    logic              stateChange;
    logic              wdExpired;

    // The watchdog restarts on every state change and only runs while the
    // controller waits on the reader or on the memory port.
    flash_copy_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (stateChange),
        .enable_i  (isGuardedState(state_q)),
        .expired_o (wdExpired)
    );

    // Next-state logic.  The strobe-style outputs are decoded from the next
    // state and then registered, so each output is high for exactly the
    // cycles the controller spends in the corresponding state (fl_rst_n low
    // only in ARM, fl_rd in CMD/NEXT, mem_we in WRITE, done in FIN).  A
    // completed handshake wins over a watchdog expiry in the same cycle so
    // an accepted byte is never thrown away.
    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        srcAddr_d   = srcAddr_q;
        curDst_d    = curDst_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        flAddr_d    = flAddr_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    srcAddr_d   = src_addr;
                    curDst_d    = dst_addr;
                    remaining_d = len;
                    error_d     = 1'b0;
                    if (len == '0) begin
                        state_d = FIN;
                    end else if (used_q) begin
                        state_d = ARM;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            ARM: begin
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!fl_busy) begin
                    flAddr_d = srcAddr_q;
                    state_d  = CMD;
                end else if (wdExpired) begin
                    error_d = 1'b1;
                    state_d = TERM;
                end
            end
            CMD: begin
                used_d  = 1'b1;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (!firstWait_q && fl_data_ready && !fl_busy) begin
                    memWdata_d = fl_dout;
                    memAddr_d  = curDst_q;
                    state_d    = WRITE;
                end else if (wdExpired) begin
                    error_d = 1'b1;
                    state_d = TERM;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    remaining_d = remaining_q - 1'b1;
                    curDst_d    = curDst_q + 1'b1;
                    state_d     = (remaining_q == LEN_W'(1)) ? TERM : NEXT;
                end else if (wdExpired) begin
                    error_d = 1'b1;
                    state_d = TERM;
                end
            end
            NEXT: begin
                state_d = WAIT_DATA;
            end
            TERM: begin
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stateChange = (state_d != state_q);
        firstWait_d = (state_d == WAIT_DATA) && (state_q != WAIT_DATA);
        busy_d      = (state_d != IDLE) && (state_d != FIN);
        done_d      = (state_d == FIN);
        flRstN_d    = (state_d != ARM);
        flRd_d      = (state_d == CMD) || (state_d == NEXT);
        flTerm_d    = (state_d == TERM);
        memWe_d     = (state_d == WRITE);
    end

    // State, job bookkeeping and output registers.  A reset mid-job returns
    // everything to idle immediately and forgets that the reader was used,
    // since the reader shares the system reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            used_q      <= 1'b0;
            srcAddr_q   <= '0;
            curDst_q    <= '0;
            remaining_q <= '0;
            firstWait_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            flRstN_q    <= 1'b1;
            flAddr_q    <= '0;
            flRd_q      <= 1'b0;
            flTerm_q    <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memWe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            srcAddr_q   <= srcAddr_d;
            curDst_q    <= curDst_d;
            remaining_q <= remaining_d;
            firstWait_q <= firstWait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            flRstN_q    <= flRstN_d;
            flAddr_q    <= flAddr_d;
            flRd_q      <= flRd_d;
            flTerm_q    <= flTerm_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memWe_q     <= memWe_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign fl_rst_n     = flRstN_q;
    assign fl_addr      = flAddr_q;
    assign fl_rd        = flRd_q;
    assign fl_terminate = flTerm_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign mem_we       = memWe_q;

endmodule

// File: tb/tb_flash_copy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flash_copy_ctrl
// Bench for flash_copy_ctrl.  A behavioural flash reader (20-cycle power-up
// wait, ~16-19 cycles per byte, dead after terminate until reset) and a
// memory responder with programmable ack delay surround the controller.
// Each job's expected writes are computed from the job parameters and the
// flash content function.
// ---------------------------------------------------------------------------
module tb_flash_copy_ctrl;

    localparam int          STARTUP_WAIT = 20;
    localparam logic [23:0] TB_TIMEOUT   = 24'd100;
    localparam int          JOB_BUDGET   = 3000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [23:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic        fl_rst_n;
    logic [23:0] fl_addr;
    logic        fl_rd;
    logic        fl_terminate;
    logic [7:0]  fl_dout;
    logic        fl_data_ready;
    logic        fl_busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;

    int assertCount = 0;
    int failCount   = 0;

    int rdCount          = 0;
    int termCount        = 0;
    int rstLowCycles     = 0;
    int weCycleTotal     = 0;
    int rdViolations     = 0;
    int stableViolations = 0;

    logic [15:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    logic [23:0] cmdAddrQ[$];

    int  ackDelay  = 0;
    bit  ackEnable = 1'b1;
    bit  usedModel = 1'b0;

    flash_copy_ctrl #(
        .DST_AW  (16),
        .LEN_W   (16),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .fl_rst_n      (fl_rst_n),
        .fl_addr       (fl_addr),
        .fl_rd         (fl_rd),
        .fl_terminate  (fl_terminate),
        .fl_dout       (fl_dout),
        .fl_data_ready (fl_data_ready),
        .fl_busy       (fl_busy),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_ack       (mem_ack)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flash content: a fixed scramble of the address so every byte differs
    // from its neighbours.
    function automatic logic [7:0] flashByte(input logic [23:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ (a[23:16] + 8'h5A);
    endfunction

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash reader and memory responder, both reacting on the falling edge
    // so the controller sees their outputs at the next rising edge.
    initial begin : responders
        int          startupCnt;
        int          xferCnt;
        bit          active;
        bit          dead;
        logic [23:0] ptr;
        int          weRun;
        logic        prevWe;
        logic        prevAck;
        logic [15:0] prevAddr;
        logic [7:0]  prevData;
        fl_busy       = 1'b1;
        fl_data_ready = 1'b0;
        fl_dout       = 8'h00;
        mem_ack       = 1'b0;
        startupCnt    = STARTUP_WAIT;
        xferCnt       = 0;
        active        = 1'b0;
        dead          = 1'b0;
        ptr           = '0;
        weRun         = 0;
        prevWe        = 1'b0;
        prevAck       = 1'b0;
        prevAddr      = '0;
        prevData      = '0;
        forever begin
            @(negedge clk);
            if (!(reset_n && fl_rst_n)) begin
                if (reset_n && !fl_rst_n) rstLowCycles++;
                fl_busy       = 1'b1;
                fl_data_ready = 1'b0;
                startupCnt    = STARTUP_WAIT;
                xferCnt       = 0;
                active        = 1'b0;
                dead          = 1'b0;
            end else begin
                if (fl_terminate) begin
                    termCount++;
                    dead    = 1'b1;
                    active  = 1'b0;
                    xferCnt = 0;
                end
                if (fl_rd) begin
                    rdCount++;
                    if (fl_busy || startupCnt > 0) rdViolations++;
                end
                if (startupCnt > 0) begin
                    startupCnt--;
                    if (startupCnt == 0) fl_busy = 1'b0;
                end else if (fl_rd && !dead) begin
                    if (!active) begin
                        active = 1'b1;
                        ptr    = fl_addr;
                        cmdAddrQ.push_back(fl_addr);
                    end else begin
                        ptr = ptr + 24'd1;
                    end
                    fl_data_ready = 1'b0;
                    fl_busy       = 1'b1;
                    xferCnt       = 16 + int'($urandom_range(0, 3));
                end else if (xferCnt > 0) begin
                    xferCnt--;
                    if (xferCnt == 0) begin
                        fl_dout       = flashByte(ptr);
                        fl_data_ready = 1'b1;
                        fl_busy       = 1'b0;
                    end
                end
            end

            if (!reset_n) begin
                mem_ack = 1'b0;
                weRun   = 0;
                prevWe  = 1'b0;
                prevAck = 1'b0;
            end else begin
                if (mem_we) begin
                    weCycleTotal++;
                    if (prevWe && !prevAck && (mem_addr !== prevAddr || mem_wdata !== prevData))
                        stableViolations++;
                    weRun++;
                    mem_ack = ackEnable && (weRun > ackDelay);
                    if (mem_ack) begin
                        wrAddrQ.push_back(mem_addr);
                        wrDataQ.push_back(mem_wdata);
                    end
                end else begin
                    weRun   = 0;
                    mem_ack = 1'b0;
                end
                prevWe   = mem_we;
                prevAck  = mem_ack;
                prevAddr = mem_addr;
                prevData = mem_wdata;
            end
        end
    end

    // Runs one job and compares everything observable against the job's
    // expected outcome: written bytes, reader strobes, re-arm and status.
    task automatic applyStimulus(input logic [23:0] src, input logic [15:0] dst,
                                 input logic [15:0] n, input int midStartAt,
                                 input bit expectAbort);
        int rd0, term0, rst0, we0;
        int cycles, weRise, errRise, expWrites, expRd;
        bit expectArm;
        rd0       = rdCount;
        term0     = termCount;
        rst0      = rstLowCycles;
        we0       = weCycleTotal;
        expectArm = usedModel && (n != 0);
        wrAddrQ.delete();
        wrDataQ.delete();
        cmdAddrQ.delete();

        @(negedge clk); #1;
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start    = 1'b1;
        @(negedge clk); #1;
        start    = 1'b0;
        src_addr = 24'($urandom);
        dst_addr = 16'($urandom);
        len      = 16'($urandom);
        checkOutput("busy after start", {31'd0, busy}, {31'd0, n != 0});
        checkOutput("error cleared on start", {31'd0, error}, 32'd0);

        cycles  = 0;
        weRise  = -1;
        errRise = -1;
        while (!done && cycles < JOB_BUDGET) begin
            start = (midStartAt > 0) && (cycles == midStartAt);
            @(negedge clk); #1;
            cycles++;
            if (mem_we && weRise < 0) weRise = cycles;
            if (error && errRise < 0) errRise = cycles;
        end
        start = 1'b0;

        checkOutput("done within budget", {31'd0, done}, 32'd1);
        checkOutput("busy low at done", {31'd0, busy}, 32'd0);
        checkOutput("mem_we low at done", {31'd0, mem_we}, 32'd0);
        checkOutput("error at done", {31'd0, error}, {31'd0, expectAbort});
        if (n != 0) usedModel = 1'b1;

        expWrites = expectAbort ? 0 : int'(n);
        expRd     = expectAbort ? 1 : int'(n);
        checkOutput("write count", wrAddrQ.size(), expWrites);
        for (int i = 0; i < expWrites && i < wrAddrQ.size(); i++) begin
            checkOutput("write addr", {16'd0, wrAddrQ[i]}, {16'd0, dst + 16'(i)});
            checkOutput("write data", {24'd0, wrDataQ[i]}, {24'd0, flashByte(src + 24'(i))});
        end
        checkOutput("fl_rd count", rdCount - rd0, (n != 0) ? expRd : 0);
        checkOutput("terminate count", termCount - term0, (n != 0) ? 1 : 0);
        checkOutput("reader re-arm cycles", rstLowCycles - rst0, expectArm ? 1 : 0);
        if (n != 0) begin
            checkOutput("command count", cmdAddrQ.size(), 1);
            checkOutput("command address",
                        (cmdAddrQ.size() > 0) ? {8'd0, cmdAddrQ[0]} : 32'hFFFF_FFFF,
                        {8'd0, src});
        end else begin
            checkOutput("len0 latency", cycles, 0);
            checkOutput("len0 mem_we cycles", weCycleTotal - we0, 0);
        end
        if (expectAbort) begin
            checkOutput("timeout latency", errRise - weRise, int'(TB_TIMEOUT));
        end

        @(negedge clk); #1;
        checkOutput("idle after done", {30'd0, busy, done}, 32'd0);
    endtask

    // Starts a job, pulls reset in the middle of it and checks that every
    // output falls back to its reset value before the next clock edge.
    task automatic resetMidJob(input logic [23:0] src, input logic [15:0] dst, input logic [15:0] n);
        @(negedge clk); #1;
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start    = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("busy before reset", {31'd0, busy}, 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset busy", {31'd0, busy}, 32'd0);
        checkOutput("async reset fl_rst_n", {31'd0, fl_rst_n}, 32'd1);
        checkOutput("async reset strobes", {29'd0, fl_rd, fl_terminate, mem_we}, 32'd0);
        checkOutput("async reset fl_addr", {8'd0, fl_addr}, 32'd0);
        checkOutput("async reset mem_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk); #1;
        reset_n   = 1'b1;
        usedModel = 1'b0;
    endtask

    // Test sequence: reset values, the directed scenarios, then a handful of
    // random jobs with random ack latency.
    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset status", {29'd0, busy, done, error}, 32'd0);
        checkOutput("reset fl_rst_n", {31'd0, fl_rst_n}, 32'd1);
        checkOutput("reset strobes", {29'd0, fl_rd, fl_terminate, mem_we}, 32'd0);
        checkOutput("reset fl_addr", {8'd0, fl_addr}, 32'd0);
        checkOutput("reset mem port", {8'd0, mem_addr, mem_wdata}, 32'd0);
        reset_n = 1'b1;

        applyStimulus(24'h000100, 16'h4000, 16'd4, 0, 1'b0);
        applyStimulus(24'h020000, 16'h5000, 16'd2, 0, 1'b0);
        applyStimulus(24'h0ABCDE, 16'h6000, 16'd0, 0, 1'b0);

        ackDelay = 7;
        applyStimulus(24'h000200, 16'h1000, 16'd3, 30, 1'b0);
        checkOutput("write held steady", stableViolations, 0);

        ackDelay  = 0;
        ackEnable = 1'b0;
        applyStimulus(24'h000300, 16'h2000, 16'd3, 0, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("error sticky", {31'd0, error}, 32'd1);
        ackEnable = 1'b1;

        applyStimulus(24'h000400, 16'hFFFF, 16'd2, 0, 1'b0);

        resetMidJob(24'h000500, 16'h3000, 16'd4);
        applyStimulus(24'h000600, 16'h3100, 16'd2, 0, 1'b0);

        for (int j = 0; j < 5; j++) begin
            ackDelay = int'($urandom_range(0, 3));
            applyStimulus(24'($urandom), 16'($urandom), 16'($urandom_range(1, 5)), 0, 1'b0);
        end

        checkOutput("read strobe protocol", rdViolations, 0);
        checkOutput("write hold protocol", stableViolations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
